// File: rtl/delay_fifo_ctrl.sv
// rtl/delay_fifo_ctrl.sv - flush/pre-fill/run sequencer for a 1-bit pulse delay FIFO
module delay_fifo_ctrl #(
  parameter int MAX_DELAY    = 1024,
  parameter int DELAY_WIDTH  = $clog2(MAX_DELAY + 1),
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [DELAY_WIDTH-1:0] delay_cfg,
  input  logic                   cfg_load,
  input  logic                   clear_flags,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic                   fifo_rst,
  output logic                   fifo_wr_en,
  output logic                   fifo_rd_en,
  output logic                   running,
  output logic [1:0]             state_o,
  output logic                   overflow,
  output logic                   underflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_FILL  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [DELAY_WIDTH-1:0] LP_MAX_DELAY  = DELAY_WIDTH'(MAX_DELAY);
  localparam logic [DELAY_WIDTH-1:0] LP_FLUSH_LAST = DELAY_WIDTH'(FLUSH_CYCLES - 1);
  localparam logic [DELAY_WIDTH-1:0] LP_ONE        = DELAY_WIDTH'(1);

  state_t                 r_state;
  logic [DELAY_WIDTH-1:0] r_delay_q;
  logic [DELAY_WIDTH-1:0] r_fill_cnt;
  logic                   r_overflow;
  logic                   r_underflow;

  logic [DELAY_WIDTH-1:0] w_delay_clamped;
  logic [DELAY_WIDTH-1:0] w_fill_last;
  logic                   w_enter_flush;
  logic                   w_flag_clr;
  logic                   w_ovf_set;
  logic                   w_unf_set;
  logic                   w_wr_phase;

  // A zero delay is meaningless for a FIFO, so it is treated as one cycle
  always_comb begin
    w_delay_clamped = delay_cfg;
    if (delay_cfg == '0) begin
      w_delay_clamped = LP_ONE;
    end else if (delay_cfg > LP_MAX_DELAY) begin
      w_delay_clamped = LP_MAX_DELAY;
    end
  end

  assign w_fill_last   = r_delay_q - LP_ONE;
  assign w_wr_phase    = (r_state == S_FILL) || (r_state == S_RUN);
  // IDLE with enable, or a reload strobe in any active state, restarts the flush
  assign w_enter_flush = enable && ((r_state == S_IDLE) || cfg_load);
  assign w_flag_clr    = clear_flags || w_enter_flush;
  assign w_ovf_set     = w_wr_phase && fifo_full;
  assign w_unf_set     = (r_state == S_RUN) && fifo_empty;

  // Sequencer: IDLE -> FLUSH -> FILL -> RUN, with enable/cfg_load overrides
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_delay_q  <= '0;
      r_fill_cnt <= '0;
    end else if (!enable) begin
      r_state    <= S_IDLE;
      r_fill_cnt <= '0;
    end else if (w_enter_flush) begin
      r_state    <= S_FLUSH;
      r_delay_q  <= w_delay_clamped;
      r_fill_cnt <= '0;
    end else begin
      case (r_state)
        S_FLUSH: begin
          if (r_fill_cnt == LP_FLUSH_LAST) begin
            r_state    <= S_FILL;
            r_fill_cnt <= '0;
          end else begin
            r_fill_cnt <= r_fill_cnt + LP_ONE;
          end
        end
        S_FILL: begin
          // Leaving on delay_q-1 keeps the counter below MAX_DELAY and gives delay_q writes
          if (r_fill_cnt == w_fill_last) begin
            r_state <= S_RUN;
          end else begin
            r_fill_cnt <= r_fill_cnt + LP_ONE;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set || (r_overflow && !w_flag_clr);
      r_underflow <= w_unf_set || (r_underflow && !w_flag_clr);
    end
  end

  assign fifo_rst   = (r_state == S_IDLE) || (r_state == S_FLUSH);
  assign fifo_wr_en = w_wr_phase && !fifo_full;
  assign fifo_rd_en = (r_state == S_RUN) && !fifo_empty;
  assign running    = (r_state == S_RUN);
  assign state_o    = r_state;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_delay_fifo_ctrl.sv
// tb/tb_delay_fifo_ctrl.sv - self-checking bench for delay_fifo_ctrl with a model FIFO
module tb_delay_fifo_ctrl;

  localparam int MAX_DELAY = 1024;
  localparam int DW        = $clog2(MAX_DELAY + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [DW-1:0] delay_cfg;
  logic          cfg_load;
  logic          clear_flags;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_rst;
  logic          fifo_wr_en;
  logic          fifo_rd_en;
  logic          running;
  logic [1:0]    state_o;
  logic          overflow;
  logic          underflow;

  logic          din;
  logic          force_empty;
  int            depth;
  int            mcnt;
  int            cyc;
  logic          mem_q[$];
  int            exp_q[$];
  int            n_checks;
  int            n_errors;
  logic [7:0]    vec;

  delay_fifo_ctrl #(.MAX_DELAY(MAX_DELAY), .DELAY_WIDTH(DW), .FLUSH_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .delay_cfg(delay_cfg), .cfg_load(cfg_load),
    .clear_flags(clear_flags), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_rst(fifo_rst), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .running(running), .state_o(state_o), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  assign fifo_full  = (mcnt >= depth);
  assign fifo_empty = (mcnt == 0) || force_empty;
  assign vec        = {fifo_rst, fifo_wr_en, fifo_rd_en, running, state_o, overflow, underflow};

  // Model FIFO plus scoreboard: each pulse read must come out at its expected edge index
  always @(posedge clk) begin
    logic v;
    int   e;
    if (fifo_rst) begin
      mem_q.delete();
    end else begin
      if (fifo_rd_en && mem_q.size() > 0) begin
        v = mem_q.pop_front();
        if (v) begin
          e = (exp_q.size() > 0) ? exp_q[0] : -1;
          n_checks++;
          assert (e === cyc) else begin
            n_errors++;
            $error("FAIL scoreboard_pulse: observed read at edge %0d expected %0d", cyc, e);
          end
          if (exp_q.size() > 0) exp_q.pop_front();
        end
      end
      if (fifo_wr_en && mem_q.size() < depth) mem_q.push_back(din);
    end
    mcnt <= mem_q.size();
    cyc  <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int max_cyc, input string tag);
    int n = 0;
    while (state_o !== s && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state_o), 32'(s));
  endtask

  task automatic pulse_empty();
    force_empty = 1'b1;
    @(negedge clk);
    force_empty = 1'b0;
  endtask

  initial begin
    int  n;
    bit  ok;
    logic placed;
    n_checks = 0; n_errors = 0; cyc = 0; mcnt = 0; depth = 2048;
    rst = 1'b1; enable = 1'b0; delay_cfg = '0; cfg_load = 1'b0; clear_flags = 1'b0;
    din = 1'b0; force_empty = 1'b0;
    #1;
    chk("reset_outputs", 32'(vec), 32'h80);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'(vec), 32'h80);

    // Delay 50: five fifo_rst cycles, 50 write-only cycles, then continuous reads
    delay_cfg = DW'(50);
    enable = 1'b1;
    n = 0;
    while (fifo_rst === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("fifo_rst_cycles", 32'(n), 32'd5);
    chk("fill_entry_state", 32'(state_o), 32'd2);
    din = 1'b1;
    exp_q.push_back(cyc + 50);
    n = 0;
    while (fifo_wr_en === 1'b1 && fifo_rd_en === 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
      din = 1'b0;
    end
    chk("write_only_cycles", 32'(n), 32'd50);
    chk("run_rd_running", 32'({fifo_rd_en, running}), 32'd3);
    ok = 1'b1;
    repeat (20) begin
      ok = ok && fifo_rd_en && fifo_wr_en && running;
      @(negedge clk);
    end
    chk("run_continuous", 32'(ok), 32'd1);
    chk("pulse_emitted_50", 32'(exp_q.size()), 32'd0);
    chk("no_flags_50", 32'({overflow, underflow}), 32'd0);

    // Forced empty for one cycle in RUN
    force_empty = 1'b1;
    #1;
    chk("rd_en_blocked", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    force_empty = 1'b0;
    chk("underflow_set", 32'(underflow), 32'd1);
    #1;
    chk("rd_en_resumes", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    chk("underflow_sticky", 32'(underflow), 32'd1);
    force_empty = 1'b1;
    clear_flags = 1'b1;
    @(negedge clk);
    force_empty = 1'b0;
    clear_flags = 1'b0;
    chk("set_wins_over_clear", 32'(underflow), 32'd1);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("underflow_cleared", 32'(underflow), 32'd0);

    // cfg_load to delay 10 while RUN with a flag set
    pulse_empty();
    chk("underflow_before_load", 32'(underflow), 32'd1);
    delay_cfg = DW'(10);
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    chk("load_to_flush", 32'({state_o, fifo_rst}), 32'({2'd1, 1'b1}));
    chk("load_clears_flags", 32'({overflow, underflow}), 32'd0);
    n = 0;
    placed = 1'b0;
    while (fifo_rd_en !== 1'b1 && n < 100) begin
      if (state_o === 2'd2 && !placed) begin
        din = 1'b1;
        exp_q.push_back(cyc + 10);
        placed = 1'b1;
      end
      n++;
      @(negedge clk);
      din = 1'b0;
    end
    chk("first_read_after_flush_10", 32'(n), 32'd14);
    repeat (3) @(negedge clk);
    chk("pulse_emitted_10", 32'(exp_q.size()), 32'd0);

    // delay_cfg = 0 behaves as delay 1
    delay_cfg = '0;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    wait_state(2'd2, 20, "fill_entry_d0");
    din = 1'b1;
    exp_q.push_back(cyc + 1);
    n = 0;
    while (state_o === 2'd2 && n < 50) begin
      n++;
      @(negedge clk);
      din = 1'b0;
    end
    chk("fill_cycles_d0", 32'(n), 32'd1);
    repeat (3) @(negedge clk);
    chk("pulse_emitted_d1", 32'(exp_q.size()), 32'd0);

    // enable dropped in FILL
    delay_cfg = DW'(50);
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    wait_state(2'd2, 20, "fill_entry_disable");
    enable = 1'b0;
    @(negedge clk);
    chk("disable_in_fill", 32'(vec), 32'h80);

    // Asynchronous reset in RUN
    delay_cfg = DW'(5);
    enable = 1'b1;
    wait_state(2'd3, 50, "run_entry_d5");
    pulse_empty();
    chk("underflow_before_rst", 32'(underflow), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_in_run", 32'(vec), 32'h80);
    depth = MAX_DELAY - 1;
    delay_cfg = DW'(MAX_DELAY);
    @(negedge clk);
    rst = 1'b0;

    // Max delay into an undersized FIFO overflows at the end of FILL
    wait_state(2'd3, 1100, "run_entry_max");
    chk("overflow_at_fill_end", 32'({overflow, fifo_wr_en, fifo_rd_en}), 32'b101);
    repeat (2) @(negedge clk);
    chk("overflow_sticky", 32'({overflow, fifo_wr_en}), 32'b11);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("overflow_cleared", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
